cpu_subsystem_ctrl: RTL and testbench
=====================================

Name: cpu_subsystem_ctrl

Overview:
- Parametrised control companion for the CPU subsystem. It replaces the hard-tied fetch_enable and the zeroed irq_ack/irq_id with real logic.
- Sequences fetch enable after reset and supports halt/resume, draining outstanding OBI instruction transactions before a halt completes.
- Conditions core interrupts: per-line edge/level mode on the fast lines, sticky pending bits, and a registered priority-encoded id with an ack pulse.
- Qualifies the core's sleep indication into a filtered sleep request for the power/clock-gating logic.

Parameters:
- NUM_FAST_IRQ, 16, number of fast interrupt lines used, taken from irq_i[16 +: NUM_FAST_IRQ]; legal range 1..16.
- FAST_IRQ_EDGE, 16'h0000, per-line mode for fast lines: 1 = rising-edge sticky, 0 = level.
- BOOT_DELAY, 4, cycles from reset release to fetch_enable_o; legal range 1..255.
- MAX_OUTSTANDING, 2, maximum outstanding instruction transactions tracked by the counter.
- SLEEP_FILTER, 8, consecutive cycles of qualified sleep required before sleep_o asserts; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- fetch_halt_i  in  1  level request to halt instruction fetch.
- fetch_enable_o  out  1  fetch enable to the core.
- halted_o  out  1  high while in HALTED.
- instr_req_i  in  1  core OBI instruction request (monitored).
- instr_gnt_i  in  1  OBI instruction grant (monitored).
- instr_rvalid_i  in  1  OBI instruction response valid (monitored).
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  count of outstanding instruction transactions.
- irq_i  in  32  raw CLINT and fast interrupt lines.
- irq_clear_i  in  NUM_FAST_IRQ  software clear of edge-pending bits.
- irq_o  out  32  conditioned interrupts to the core.
- irq_valid_o  out  1  at least one conditioned interrupt is active.
- irq_id_o  out  5  id of the highest-priority active interrupt.
- irq_ack_o  out  1  one-cycle pulse on a new irq id.
- core_sleep_i  in  1  core sleep indication.
- sleep_o  out  1  filtered sleep request.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst_i). During reset all outputs, counters, pending bits and registers are 0, and the FSM is in BOOT with the boot counter at 0.
- FSM states: BOOT, RUN, DRAIN, HALTED.
  - BOOT: counts cycles after reset release. Moves to RUN when the count reaches BOOT_DELAY-1, so fetch_enable_o first goes high exactly BOOT_DELAY cycles after the first clock edge with rst_i low. If fetch_halt_i=1 in BOOT, move to HALTED directly.
  - RUN: fetch_enable_o=1. fetch_halt_i=1 moves to DRAIN.
  - DRAIN: fetch_enable_o=0. Move to HALTED in the first cycle in which outstanding_o==0 and no gnt arrives in that cycle. Dropping fetch_halt_i in DRAIN does not abort it; DRAIN always completes.
  - HALTED: halted_o=1, fetch_enable_o=0. fetch_halt_i=0 moves to RUN on the next cycle.
- fetch_enable_o and halted_o are registered.
- Outstanding counter:
  - +1 on instr_req_i&instr_gnt_i; -1 on instr_rvalid_i; both in the same cycle leaves it unchanged.
  - Saturates at MAX_OUTSTANDING and at 0: an rvalid with count 0 is ignored.
  - An overflow attempt fires a simulation assertion.
- Interrupt conditioning:
  - irq_o[3], irq_o[7], irq_o[11] are registered copies of irq_i (one-cycle latency).
  - For fast line i with edge mode: pending[i] sets on a 0->1 transition of irq_i[16+i] (previous-value register, reset 0) and clears on irq_clear_i[i]. If set and clear occur in the same cycle, set wins. irq_o[16+i] = pending[i].
  - For fast line i with level mode: irq_o[16+i] is the registered irq_i, and irq_clear_i[i] is ignored.
  - All other irq_o bits are 0.
- Priority and id (computed from irq_o, registered, so irq_id_o/irq_valid_o lag irq_o by one cycle):
  - Highest fast index first (31 down to 16), then 11, 3, 7.
  - irq_valid_o = OR of irq_o; irq_id_o = 0 when not valid.
  - irq_ack_o pulses for one cycle when irq_valid_o rises, or when irq_id_o changes to a different valid id.
- Sleep filter:
  - Qualified sleep = core_sleep_i & (outstanding_o==0) & ~irq_valid_o.
  - A counter runs while qualified sleep holds and resets to 0 when it drops.
  - sleep_o=1 once the counter reaches SLEEP_FILTER; sleep_o drops in the cycle after qualified sleep deasserts.
  - The counter saturates at SLEEP_FILTER.
- Reset asserted mid-operation: all state returns to the reset values immediately, and BOOT restarts on release.

Test Plan:
- Release reset with BOOT_DELAY=4 and fetch_halt_i=0 -> fetch_enable_o rises on the 4th rising edge after release; halted_o stays 0.
- In RUN, issue 2 granted requests with no rvalid, then assert fetch_halt_i -> fetch_enable_o=0 next cycle, FSM holds DRAIN with outstanding_o=2; after 2 rvalids, halted_o=1 one cycle later; deassert fetch_halt_i -> fetch_enable_o=1 next cycle.
- With FAST_IRQ_EDGE bit0=1, pulse irq_i[16] for one cycle -> irq_o[16] stays 1; irq_id_o=16, irq_valid_o=1 and irq_ack_o pulses once; irq_clear_i[0] clears it; a clear coincident with a new rising edge leaves the bit set.
- Drive irq_i[11] and irq_i[20] (level) together -> irq_id_o=20; drop irq_i[20] -> irq_id_o=11 with an irq_ack_o pulse; with irq_i[3] and irq_i[7] both active -> irq_id_o=3.
- Hold core_sleep_i=1 with no outstanding transactions and no interrupts, SLEEP_FILTER=8 -> sleep_o rises after 8 cycles; raise irq_i[7] -> sleep_o falls and the counter restarts from 0.
- Assert rst_i asynchronously mid-DRAIN with outstanding_o=1 -> all outputs 0 immediately, outstanding_o=0; BOOT repeats on release.

Source files
------------

// File: rtl/cpu_subsystem_ctrl.sv
// cpu_subsystem_ctrl
//   Control companion for the CPU subsystem:
//   - sequences fetch enable after reset, with halt/resume and OBI drain,
//   - tracks outstanding instruction transactions,
//   - conditions the core interrupt lines and produces a registered
//     priority-encoded id with an acknowledge pulse,
//   - filters the core sleep indication into a sleep request.
module cpu_subsystem_ctrl #(
    parameter int          NUM_FAST_IRQ    = 16,
    parameter logic [15:0] FAST_IRQ_EDGE   = 16'h0000,
    parameter int          BOOT_DELAY      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          SLEEP_FILTER    = 8,
    localparam int         OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    // fetch sequencing
    input  logic                    fetch_halt_i,
    output logic                    fetch_enable_o,
    output logic                    halted_o,

    // OBI instruction channel monitor
    input  logic                    instr_req_i,
    input  logic                    instr_gnt_i,
    input  logic                    instr_rvalid_i,
    output logic [OUT_W-1:0]        outstanding_o,

    // interrupt conditioning
    input  logic [31:0]             irq_i,
    input  logic [NUM_FAST_IRQ-1:0] irq_clear_i,
    output logic [31:0]             irq_o,
    output logic                    irq_valid_o,
    output logic [4:0]              irq_id_o,
    output logic                    irq_ack_o,

    // sleep qualification
    input  logic                    core_sleep_i,
    output logic                    sleep_o
);

    localparam int          SLEEP_W   = $clog2(SLEEP_FILTER + 1);
    localparam logic [7:0]  BOOT_LAST = 8'(BOOT_DELAY - 1);
    localparam logic [OUT_W-1:0]   OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SLEEP_W-1:0] SLEEP_MAX = SLEEP_W'(SLEEP_FILTER);

    // ------------------------------------------------------------------
    // Fetch sequencing FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  boot_cnt_reg;
    logic [7:0]  boot_cnt_next;
    logic        fetch_enable_reg;
    logic        fetch_enable_next;
    logic        halted_reg;
    logic        halted_next;

    // Outstanding-transaction tracking signals (used by the FSM drain exit)
    logic [OUT_W-1:0] out_cnt_reg;
    logic [OUT_W-1:0] out_cnt_next;
    logic             grant;
    logic             retire;
    logic             overflow;

    assign grant  = instr_req_i & instr_gnt_i;
    // A response with nothing outstanding is ignored.
    assign retire = instr_rvalid_i & (out_cnt_reg != '0);

    // State register plus the registered fetch_enable/halted outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= ST_BOOT;
            boot_cnt_reg     <= '0;
            fetch_enable_reg <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            boot_cnt_reg     <= boot_cnt_next;
            fetch_enable_reg <= fetch_enable_next;
            halted_reg       <= halted_next;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that
    // the registered outputs line up with the state they describe.
    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        case (state_reg)
            ST_BOOT: begin
                if (fetch_halt_i) begin
                    state_next = ST_HALTED;
                end else if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 8'd1;
                end
            end
            ST_RUN: begin
                if (fetch_halt_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Drain always completes, even if the halt request drops.
                if ((out_cnt_reg == '0) && !grant) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!fetch_halt_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
        fetch_enable_next = (state_next == ST_RUN);
        halted_next       = (state_next == ST_HALTED);
    end

    assign fetch_enable_o = fetch_enable_reg;
    assign halted_o       = halted_reg;

    // ------------------------------------------------------------------
    // Outstanding instruction transaction counter
    // ------------------------------------------------------------------

    // Counter update: saturates at both ends, simultaneous grant/retire holds
    always_comb begin
        out_cnt_next = out_cnt_reg;
        if (grant && !retire) begin
            if (out_cnt_reg != OUT_MAX) begin
                out_cnt_next = out_cnt_reg + OUT_W'(1);
            end
        end else if (retire && !grant) begin
            out_cnt_next = out_cnt_reg - OUT_W'(1);
        end
    end

    assign overflow = grant & ~retire & (out_cnt_reg == OUT_MAX);

    // Outstanding counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_reg <= '0;
        end else begin
            out_cnt_reg <= out_cnt_next;
        end
    end

    // A grant with the counter already full means the tracker lost count.
    overflow_never : assert property (@(posedge clk_i) disable iff (rst_i) !overflow);

    assign outstanding_o = out_cnt_reg;

    // ------------------------------------------------------------------
    // Interrupt conditioning
    // ------------------------------------------------------------------
    logic [31:0] irq_in_reg;      // registered irq_i, also the edge-detect history
    logic [15:0] pending_reg;
    logic [15:0] pending_next;
    logic [15:0] fast_cond;
    logic [31:0] irq_cond;

    for (genvar gi = 0; gi < 16; gi++) begin : g_fast
        if (gi < NUM_FAST_IRQ) begin : g_used
            if (FAST_IRQ_EDGE[gi]) begin : g_edge
                // Set on a rising edge wins over a coincident clear.
                assign pending_next[gi] = (irq_i[16+gi] & ~irq_in_reg[16+gi])
                                        | (pending_reg[gi] & ~irq_clear_i[gi]);
                assign fast_cond[gi]    = pending_reg[gi];
            end else begin : g_level
                assign pending_next[gi] = 1'b0;
                assign fast_cond[gi]    = irq_in_reg[16+gi];
            end
        end else begin : g_unused
            assign pending_next[gi] = 1'b0;
            assign fast_cond[gi]    = 1'b0;
        end
    end

    // Input sampling and sticky pending bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_in_reg  <= '0;
            pending_reg <= '0;
        end else begin
            irq_in_reg  <= irq_i;
            pending_reg <= pending_next;
        end
    end

    // Only the CLINT software/timer/external lines and the fast lines pass.
    assign irq_cond = {fast_cond, 4'b0000,
                       irq_in_reg[11], 3'b000,
                       irq_in_reg[7],  3'b000,
                       irq_in_reg[3],  3'b000};
    assign irq_o = irq_cond;

    // ------------------------------------------------------------------
    // Priority encoder, id and acknowledge
    // ------------------------------------------------------------------
    logic       irq_valid_reg;
    logic       irq_valid_next;
    logic [4:0] irq_id_reg;
    logic [4:0] irq_id_next;
    logic       irq_ack_reg;
    logic       irq_ack_next;

    // Priority: fast lines 31..16 highest first, then 11, 3, 7.
    // Later assignments override earlier ones, so lowest priority goes first.
    always_comb begin
        irq_id_next = 5'd0;
        if (irq_cond[7]) begin
            irq_id_next = 5'd7;
        end
        if (irq_cond[3]) begin
            irq_id_next = 5'd3;
        end
        if (irq_cond[11]) begin
            irq_id_next = 5'd11;
        end
        for (int i = 16; i < 32; i++) begin
            if (irq_cond[i]) begin
                irq_id_next = 5'(i);
            end
        end
        irq_valid_next = |irq_cond;
        irq_ack_next   = irq_valid_next & (~irq_valid_reg | (irq_id_next != irq_id_reg));
    end

    // Registered id, valid and acknowledge pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_valid_reg <= 1'b0;
            irq_id_reg    <= '0;
            irq_ack_reg   <= 1'b0;
        end else begin
            irq_valid_reg <= irq_valid_next;
            irq_id_reg    <= irq_id_next;
            irq_ack_reg   <= irq_ack_next;
        end
    end

    assign irq_valid_o = irq_valid_reg;
    assign irq_id_o    = irq_id_reg;
    assign irq_ack_o   = irq_ack_reg;

    // ------------------------------------------------------------------
    // Sleep filter
    // ------------------------------------------------------------------
    logic               sleep_qual;
    logic [SLEEP_W-1:0] sleep_cnt_reg;
    logic [SLEEP_W-1:0] sleep_cnt_next;
    logic               sleep_reg;
    logic               sleep_next;

    assign sleep_qual = core_sleep_i & (out_cnt_reg == '0) & ~irq_valid_reg;

    // Run-length counter of qualified sleep, saturating at the filter length
    always_comb begin
        sleep_cnt_next = sleep_cnt_reg;
        if (!sleep_qual) begin
            sleep_cnt_next = '0;
        end else if (sleep_cnt_reg != SLEEP_MAX) begin
            sleep_cnt_next = sleep_cnt_reg + SLEEP_W'(1);
        end
        sleep_next = (sleep_cnt_next == SLEEP_MAX);
    end

    // Sleep counter and registered sleep request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sleep_cnt_reg <= '0;
            sleep_reg     <= 1'b0;
        end else begin
            sleep_cnt_reg <= sleep_cnt_next;
            sleep_reg     <= sleep_next;
        end
    end

    assign sleep_o = sleep_reg;

    // Raw lines that are not forwarded, clears of level lines and pending
    // bits of level lines are intentionally left without a load.
    logic unused_ok;
    assign unused_ok = ^{irq_in_reg, irq_clear_i, pending_reg};

endmodule

// File: tb/tb_cpu_subsystem_ctrl.sv
// Testbench for cpu_subsystem_ctrl: directed steps from the test plan
// followed by randomized bursts, all checked against a behavioural model.
module tb_cpu_subsystem_ctrl;

    localparam int          BD        = 4;
    localparam int          MAXO      = 2;
    localparam int          SF        = 8;
    localparam logic [15:0] EDGE_MASK = 16'h0005;   // lines 16 and 18 edge-mode

    localparam int M_BOOT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_halt;
    logic        fetch_enable;
    logic        halted;
    logic        instr_req;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [1:0]  outstanding;
    logic [31:0] irq_in;
    logic [15:0] irq_clear;
    logic [31:0] irq_out;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ack;
    logic        core_sleep;
    logic        sleep;

    always #5 clk = ~clk;

    cpu_subsystem_ctrl #(
        .NUM_FAST_IRQ    (16),
        .FAST_IRQ_EDGE   (EDGE_MASK),
        .BOOT_DELAY      (BD),
        .MAX_OUTSTANDING (MAXO),
        .SLEEP_FILTER    (SF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_halt_i   (fetch_halt),
        .fetch_enable_o (fetch_enable),
        .halted_o       (halted),
        .instr_req_i    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .outstanding_o  (outstanding),
        .irq_i          (irq_in),
        .irq_clear_i    (irq_clear),
        .irq_o          (irq_out),
        .irq_valid_o    (irq_valid),
        .irq_id_o       (irq_id),
        .irq_ack_o      (irq_ack),
        .core_sleep_i   (core_sleep),
        .sleep_o        (sleep)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- behavioural model ----------------
    int          m_mode;
    int          m_boot;
    int          m_out;
    int          m_run;       // consecutive cycles of qualified sleep (unbounded)
    logic [31:0] m_seen;      // irq_i as sampled at the last edge
    logic [15:0] m_pend;
    bit          m_valid;
    int          m_id;
    bit          m_ack;
    int          prio_list[19];

    function automatic logic [31:0] model_irq_o();
        logic [31:0] v;
        v = '0;
        v[3]  = m_seen[3];
        v[7]  = m_seen[7];
        v[11] = m_seen[11];
        for (int i = 0; i < 16; i++) begin
            v[16+i] = EDGE_MASK[i] ? m_pend[i] : m_seen[16+i];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode  = M_BOOT;
        m_boot  = 0;
        m_out   = 0;
        m_run   = 0;
        m_seen  = '0;
        m_pend  = '0;
        m_valid = 0;
        m_id    = 0;
        m_ack   = 0;
    endtask

    task automatic model_step();
        logic [31:0] cond_old;
        int          out_old;
        bit          valid_old;
        int          id_old;
        bit          new_valid;
        int          new_id;
        bit          qual;
        if (rst) begin
            model_reset();
            return;
        end
        cond_old  = model_irq_o();
        out_old   = m_out;
        valid_old = m_valid;
        id_old    = m_id;

        case (m_mode)
            M_BOOT: begin
                if (fetch_halt) m_mode = M_HALTED;
                else if (m_boot == BD - 1) m_mode = M_RUN;
                else m_boot++;
            end
            M_RUN:    if (fetch_halt) m_mode = M_DRAIN;
            M_DRAIN:  if (out_old == 0 && !(instr_req && instr_gnt)) m_mode = M_HALTED;
            default:  if (!fetch_halt) m_mode = M_RUN;
        endcase

        if ((instr_req && instr_gnt) && !(instr_rvalid && out_old > 0)) begin
            if (m_out < MAXO) m_out++;
        end else if (instr_rvalid && out_old > 0 && !(instr_req && instr_gnt)) begin
            m_out--;
        end

        qual  = core_sleep && (out_old == 0) && !valid_old;
        m_run = qual ? m_run + 1 : 0;

        for (int i = 0; i < 16; i++) begin
            if (EDGE_MASK[i]) begin
                if (irq_in[16+i] && !m_seen[16+i]) m_pend[i] = 1'b1;
                else if (irq_clear[i]) m_pend[i] = 1'b0;
            end
        end
        m_seen = irq_in;

        new_valid = 0;
        new_id    = 0;
        for (int k = 0; k < 19; k++) begin
            if (!new_valid && cond_old[prio_list[k]]) begin
                new_valid = 1;
                new_id    = prio_list[k];
            end
        end
        m_ack   = new_valid && (!valid_old || new_id != id_old);
        m_valid = new_valid;
        m_id    = new_id;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("fetch_enable", 32'(fetch_enable), 32'(m_mode == M_RUN));
        chk("halted",       32'(halted),       32'(m_mode == M_HALTED));
        chk("outstanding",  32'(outstanding),  32'(m_out));
        chk("irq_o",        irq_out,           model_irq_o());
        chk("irq_valid",    32'(irq_valid),    32'(m_valid));
        chk("irq_id",       32'(irq_id),       32'(m_id));
        chk("irq_ack",      32'(irq_ack),      32'(m_ack));
        chk("sleep",        32'(sleep),        32'(m_run >= SF));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Watchdog: the run is bounded by construction, this only guards a stall.
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) prio_list[i] = 31 - i;
        prio_list[16] = 11;
        prio_list[17] = 3;
        prio_list[18] = 7;

        rst          = 1'b1;
        fetch_halt   = 1'b0;
        instr_req    = 1'b0;
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
        irq_in       = '0;
        irq_clear    = '0;
        core_sleep   = 1'b0;
        model_reset();

        // ---- reset state ----
        repeat (2) tick();
        chk("reset_fetch_enable", 32'(fetch_enable), 32'd0);
        chk("reset_halted",       32'(halted),       32'd0);
        chk("reset_outstanding",  32'(outstanding),  32'd0);
        $display("[TB] reset state checked");

        // ---- boot sequence ----
        rst = 1'b0;
        for (int k = 1; k <= BD; k++) begin
            tick();
            chk("boot_fetch_enable", 32'(fetch_enable), 32'(k == BD));
            chk("boot_halted",       32'(halted),       32'd0);
        end
        $display("[TB] boot sequence: fetch enabled after %0d edges", BD);

        // ---- halt with drain ----
        instr_req = 1'b1; instr_gnt = 1'b1;
        tick(); tick();
        instr_req = 1'b0; instr_gnt = 1'b0; fetch_halt = 1'b1;
        tick();
        chk("drain_fetch_enable", 32'(fetch_enable), 32'd0);
        chk("drain_outstanding",  32'(outstanding),  32'd2);
        tick(); tick();
        chk("drain_hold_halted",  32'(halted),       32'd0);
        instr_rvalid = 1'b1;
        tick(); tick();
        instr_rvalid = 1'b0;
        chk("drain_empty_out",    32'(outstanding),  32'd0);
        chk("drain_not_yet",      32'(halted),       32'd0);
        tick();
        chk("drain_halted",       32'(halted),       32'd1);
        fetch_halt = 1'b0;
        tick();
        chk("resume_fetch_enable", 32'(fetch_enable), 32'd1);
        chk("resume_halted",       32'(halted),       32'd0);
        $display("[TB] halt/drain/resume sequence done");

        // ---- edge-mode fast interrupt ----
        irq_in[16] = 1'b1;
        tick();
        chk("edge_set", 32'(irq_out[16]), 32'd1);
        irq_in[16] = 1'b0;
        tick();
        chk("edge_sticky", 32'(irq_out[16]), 32'd1);
        chk("edge_id",     32'(irq_id),      32'd16);
        chk("edge_valid",  32'(irq_valid),   32'd1);
        chk("edge_ack",    32'(irq_ack),     32'd1);
        tick();
        chk("edge_ack_once", 32'(irq_ack),   32'd0);
        irq_clear[0] = 1'b1;
        tick();
        irq_clear[0] = 1'b0;
        chk("edge_cleared", 32'(irq_out[16]), 32'd0);
        tick(); tick();
        irq_in[16] = 1'b1;
        tick();
        irq_in[16] = 1'b0;
        tick();
        irq_in[16] = 1'b1; irq_clear[0] = 1'b1;
        tick();
        chk("edge_set_wins", 32'(irq_out[16]), 32'd1);
        tick();
        chk("edge_clear_no_rise", 32'(irq_out[16]), 32'd0);
        irq_in = '0; irq_clear = '0;
        tick(); tick();
        $display("[TB] edge-mode interrupt sequence done");

        // ---- level-mode priority ----
        irq_in[11] = 1'b1; irq_in[20] = 1'b1;
        tick(); tick();
        chk("prio_20_over_11", 32'(irq_id), 32'd20);
        irq_in[20] = 1'b0;
        tick(); tick();
        chk("prio_11",     32'(irq_id),  32'd11);
        chk("prio_11_ack", 32'(irq_ack), 32'd1);
        irq_in = '0; irq_in[3] = 1'b1; irq_in[7] = 1'b1;
        tick(); tick();
        chk("prio_3_over_7", 32'(irq_id), 32'd3);
        $display("[TB] interrupt priority sequence done");

        // ---- sleep filter ----
        irq_in = '0;
        repeat (3) tick();
        core_sleep = 1'b1;
        for (int k = 1; k <= SF; k++) begin
            tick();
            chk("sleep_filter", 32'(sleep), 32'(k == SF));
        end
        irq_in[7] = 1'b1;
        repeat (3) tick();
        chk("sleep_drop_on_irq", 32'(sleep), 32'd0);
        irq_in = '0;
        repeat (12) tick();
        $display("[TB] sleep filter sequence done");

        // ---- asynchronous reset mid-drain ----
        core_sleep = 1'b0;
        repeat (2) tick();
        instr_req = 1'b1; instr_gnt = 1'b1;
        tick();
        instr_req = 1'b0; instr_gnt = 1'b0; fetch_halt = 1'b1;
        tick();
        chk("pre_reset_outstanding", 32'(outstanding), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_fetch_enable", 32'(fetch_enable), 32'd0);
        chk("async_halted",       32'(halted),       32'd0);
        chk("async_outstanding",  32'(outstanding),  32'd0);
        chk("async_irq_o",        irq_out,           32'd0);
        chk("async_irq_valid",    32'(irq_valid),    32'd0);
        chk("async_irq_id",       32'(irq_id),       32'd0);
        chk("async_irq_ack",      32'(irq_ack),      32'd0);
        chk("async_sleep",        32'(sleep),        32'd0);
        tick();
        rst = 1'b0; fetch_halt = 1'b0;
        for (int k = 1; k <= BD; k++) begin
            tick();
            chk("reboot_fetch_enable", 32'(fetch_enable), 32'(k == BD));
        end
        $display("[TB] asynchronous reset and reboot done");

        // ---- randomized bursts ----
        for (int b = 0; b < 12; b++) begin
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 19) == 0) fetch_halt = ~fetch_halt;
                instr_req    = 1'($urandom_range(0, 1));
                instr_gnt    = 1'($urandom_range(0, 1));
                instr_rvalid = (m_out > 0) && ($urandom_range(0, 2) == 0);
                if (m_out == MAXO && !instr_rvalid) instr_gnt = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    int sel;
                    sel = prio_list[$urandom_range(0, 18)];
                    irq_in[sel] = ~irq_in[sel];
                end
                irq_clear  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
                core_sleep = ($urandom_range(0, 3) != 0);
                tick();
            end
            // quiet tail: drain, clear interrupts and let the sleep filter run
            fetch_halt = 1'b0;
            instr_req  = 1'b0;
            instr_gnt  = 1'b0;
            irq_in     = '0;
            irq_clear  = 16'hFFFF;
            core_sleep = 1'b1;
            for (int c = 0; c < 40; c++) begin
                instr_rvalid = (m_out > 0);
                tick();
                irq_clear = '0;
            end
            instr_rvalid = 1'b0;
            $display("[TB] random burst %0d done, checks so far %0d", b, tests);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
